pipe_adder: RTL and testbench

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder.sv | 115 +++++++++++
 tb/tb_pipe_adder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_adder.sv
// Pipelined ripple adder/subtractor: STAGE_BITS of carry chain per stage, carry
// and skewed operand/result slices registered between stages, valid/ready handshake.
module pipe_adder #(
    parameter int WIDTH      = 16,
    parameter int STAGE_BITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSTAGES = WIDTH / STAGE_BITS;
    localparam int SB      = STAGE_BITS;
    localparam int LS      = NSTAGES - 1;

    logic             adv_s;
    logic             ovf_s;
    logic             out_valid_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;

    assign adv_s    = !out_valid_r || out_ready;
    assign in_ready = adv_s;

    // Stage k consumes the low SB bits of the operands it receives and forwards
    // the rest; the resolved result grows by SB bits per stage.
    for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
        localparam int RW = WIDTH - k * SB;
        localparam int DW = (k + 1) * SB;

        logic [RW-1:0] op_a_s;
        logic [RW-1:0] op_b_s;
        logic          c_in_s;
        logic          v_s;
        logic [SB:0]   slice_s;
        logic [DW-1:0] res_s;

        assign slice_s = {1'b0, op_a_s[SB-1:0]} + {1'b0, op_b_s[SB-1:0]}
                       + {{SB{1'b0}}, c_in_s};

        if (k == 0) begin : g_in
            // Subtract is folded in as a + ~b + !cin.
            assign op_a_s = a;
            assign op_b_s = b ^ {WIDTH{sub}};
            assign c_in_s = cin ^ sub;
            assign v_s    = in_valid;
            assign res_s  = slice_s[SB-1:0];
        end else begin : g_reg
            logic [RW-1:0]   a_r;
            logic [RW-1:0]   b_r;
            logic [k*SB-1:0] s_r;
            logic            c_r;
            logic            v_r;

            // Pipeline register between stage k-1 and stage k.
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_r <= 1'b0;
                    c_r <= 1'b0;
                    a_r <= {RW{1'b0}};
                    b_r <= {RW{1'b0}};
                    s_r <= {(k*SB){1'b0}};
                end else if (adv_s) begin
                    v_r <= g_stage[k-1].v_s;
                    c_r <= g_stage[k-1].slice_s[SB];
                    a_r <= g_stage[k-1].op_a_s[RW+SB-1:SB];
                    b_r <= g_stage[k-1].op_b_s[RW+SB-1:SB];
                    s_r <= g_stage[k-1].res_s;
                end
            end

            assign op_a_s = a_r;
            assign op_b_s = b_r;
            assign c_in_s = c_r;
            assign v_s    = v_r;
            assign res_s  = {slice_s[SB-1:0], s_r};
        end
    end

    // Same-sign operands producing a different-sign result == carry-in XOR carry-out of the MSB.
    assign ovf_s = (g_stage[LS].op_a_s[SB-1] == g_stage[LS].op_b_s[SB-1])
                && (g_stage[LS].slice_s[SB-1] != g_stage[LS].op_a_s[SB-1]);

    // Output register; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            sum_r       <= {WIDTH{1'b0}};
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
        end else if (adv_s) begin
            out_valid_r <= g_stage[LS].v_s;
            sum_r       <= g_stage[LS].res_s;
            cout_r      <= g_stage[LS].slice_s[SB];
            ovf_r       <= ovf_s;
        end
    end

    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_pipe_adder.sv
// Directed bench for pipe_adder (WIDTH=16, STAGE_BITS=4): vector table,
// latency, backpressure, mid-stream reset and a randomised handshake run.
module tb_pipe_adder;

    localparam int W  = 16;
    localparam int SB = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        res_t        exp;
    } vec_t;

    int   errors    = 0;
    int   checks    = 0;
    int   delivered = 0;
    int   stall_cnt = 0;
    res_t exp_q[$];

    pipe_adder #(.WIDTH(W), .STAGE_BITS(SB)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Reference built from plain integer arithmetic.
    function automatic res_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic c, input logic s);
        logic [16:0] t;
        int          v;
        res_t        r;
        if (s) begin
            t      = {1'b0, x} - {1'b0, y} - {16'b0, c};
            r.cout = ~t[16];
            v      = int'($signed(x)) - int'($signed(y)) - int'(c);
        end else begin
            t      = {1'b0, x} + {1'b0, y} + {16'b0, c};
            r.cout = t[16];
            v      = int'($signed(x)) + int'($signed(y)) + int'(c);
        end
        r.sum = t[15:0];
        r.ovf = (v > 32767) || (v < -32768);
        return r;
    endfunction

    task automatic drive(input logic v, input logic [15:0] aa, input logic [15:0] bb,
                         input logic c, input logic s, input logic ordy,
                         input res_t e, output logic acc);
        in_valid  = v;
        a         = aa;
        b         = bb;
        cin       = c;
        sub       = s;
        out_ready = ordy;
        @(negedge clk);
        acc = v && in_ready && !rst;
        if (acc) exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    // Output monitor: scoreboard compare, stall stability, in_ready during stall.
    initial begin
        logic        stall_prev;
        logic [18:0] held;
        res_t        e;
        stall_prev = 1'b0;
        held       = 19'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (stall_prev)
                    check("frozen", {13'b0, out_valid, sum, cout, ovf}, {13'b0, held});
                if (out_valid && !out_ready) begin
                    stall_cnt++;
                    check("stall_in_ready", in_ready, 0);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious: got result %h required none", sum);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", {14'b0, sum, cout, ovf}, {14'b0, e.sum, e.cout, e.ovf});
                    end
                    delivered++;
                end
                stall_prev = out_valid && !out_ready;
                held       = {out_valid, sum, cout, ovf};
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[12];
        logic        acc;
        logic        seen;
        int          lat;
        int          d0;
        int          idx;
        int          s0;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic        rs;
        logic        rv;
        logic        ro;

        vecs[0]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, '{16'h0000, 1'b1, 1'b0}};
        vecs[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1}};
        vecs[2]  = '{16'h0003, 16'h0005, 1'b0, 1'b1, '{16'hFFFE, 1'b0, 1'b0}};
        vecs[3]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b1}};
        vecs[4]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, '{16'h5555, 1'b0, 1'b0}};
        vecs[5]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, '{16'hFFFF, 1'b1, 1'b0}};
        vecs[6]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b1}};
        vecs[7]  = '{16'h0005, 16'h0003, 1'b1, 1'b1, '{16'h0001, 1'b1, 1'b0}};
        vecs[8]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, '{16'h0000, 1'b1, 1'b0}};
        vecs[9]  = '{16'h0000, 16'h0000, 1'b1, 1'b1, '{16'hFFFF, 1'b0, 1'b0}};
        vecs[10] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, '{16'h8000, 1'b0, 1'b1}};
        vecs[11] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, '{16'h0100, 1'b0, 1'b0}};

        rst = 1'b1; in_valid = 1'b0; a = 16'h0; b = 16'h0;
        cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);
        @(posedge clk);
        #1;

        // Single transaction: out_valid must rise exactly NSTAGES cycles later.
        drive(1'b1, vecs[0].a, vecs[0].b, vecs[0].cin, vecs[0].sub, 1'b1, vecs[0].exp, acc);
        check("lat_accept", acc, 1);
        seen = 1'b0;
        lat  = 0;
        for (int i = 1; i <= 10 && !seen; i++) begin
            in_valid = 1'b0;
            a = 16'hDEAD; b = 16'hBEEF;
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                lat  = i;
            end
            @(posedge clk);
            #1;
        end
        check("latency", lat, 4);
        drain();

        // Table stream, back to back.
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 1'b1, vecs[i].exp, acc);
            check("stream_accept", acc, 1);
        end
        drain();

        // Backpressure: 8 transactions, consumer stalls in cycles 6..9.
        d0  = delivered;
        s0  = stall_cnt;
        idx = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            ro = !(cyc >= 6 && cyc <= 9);
            if (idx < 8) begin
                ra = 16'(idx * 16'h2345 + 16'h0F0F);
                rb = 16'(16'hFFF0 - idx * 16'h1111);
                rc = idx[0];
                rs = idx[1];
                drive(1'b1, ra, rb, rc, rs, ro, model(ra, rb, rc, rs), acc);
                if (acc) idx++;
            end else begin
                drive(1'b0, 16'h5A5A, 16'hA5A5, 1'b1, 1'b1, ro, '{16'h0, 1'b0, 1'b0}, acc);
            end
        end
        drain();
        check("bp_sent", idx, 8);
        check("bp_delivered", delivered - d0, 8);
        check("bp_stall_cycles", stall_cnt - s0, 4);

        // Reset with three transactions in flight; input offered in the reset cycle too.
        for (int i = 0; i < 3; i++) begin
            ra = 16'(16'h1111 * (i + 1));
            drive(1'b1, ra, 16'h0101, 1'b0, 1'b0, 1'b1, model(ra, 16'h0101, 1'b0, 1'b0), acc);
        end
        d0  = delivered;
        rst = 1'b1;
        drive(1'b1, 16'h4444, 16'h0101, 1'b0, 1'b0, 1'b1, '{16'h0, 1'b0, 1'b0}, acc);
        rst = 1'b0;
        exp_q.delete();
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        repeat (10) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        check("mid_rst_none", delivered - d0, 0);

        // Randomised operands and handshake.
        for (int i = 0; i < 400; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            rv = 1'($urandom_range(0, 2) != 0);
            ro = 1'($urandom_range(0, 3) != 0);
            drive(rv, ra, rb, rc, rs, ro, model(ra, rb, rc, rs), acc);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
